// File: rtl/lsc_i2cm_regrw.sv
// rtl/lsc_i2cm_regrw.sv - single-master I2C controller: one 8-bit register write or read per request
module lsc_i2cm_regrw #(
    parameter int QDIV = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl,
    output logic       o_sda
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_DONE} state_t;
    typedef enum logic [2:0] {B_DEV_W, B_REG, B_WDATA, B_RSTART, B_DEV_R, B_RDATA} byte_t;

    localparam logic [9:0] QTOP = 10'(QDIV - 1);

    state_t     state_q, state_d;
    byte_t      byte_q, byte_d;
    logic [1:0] phase_q, phase_d;
    logic [9:0] cnt_q, cnt_d;
    logic [3:0] bit_q, bit_d;
    logic       nack_q, nack_d;
    logic [7:0] rx_q, rx_d;
    logic       rw_q, rw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_err_q, ack_err_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic       phase_end, stretch_phase;
    logic [7:0] tx_byte;

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        nack_d    = nack_q;
        rx_d      = rx_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        phase_end = 1'b0;

        // The quarter counter runs down and parks at zero in the SCL-high phases
        // until the synchronized line is seen high, so a slave can stretch the clock.
        stretch_phase = (state_q == S_BIT && phase_q == 2'd2) ||
                        ((state_q == S_START || state_q == S_STOP) && phase_q == 2'd1);
        if (state_q inside {S_START, S_BIT, S_STOP}) begin
            if (cnt_q != 10'd0) begin
                cnt_d = cnt_q - 10'd1;
            end else if (!stretch_phase || scl_s2_q) begin
                phase_end = 1'b1;
                cnt_d     = QTOP;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_START;
                    byte_d    = B_DEV_W;
                    phase_d   = 2'd0;
                    cnt_d     = QTOP;
                    rw_d      = i_rw;
                    dev_d     = i_dev_addr;
                    reg_d     = i_reg_addr;
                    wdata_d   = i_wdata;
                    ack_err_d = 1'b0;
                end
            end
            S_START: begin
                if (phase_end) begin
                    if (phase_q == 2'd2) begin
                        state_d = S_BIT;
                        phase_d = 2'd0;
                        bit_d   = 4'd0;
                        if (byte_q == B_RSTART) byte_d = B_DEV_R;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (phase_end) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd2) begin
                        if (bit_q == 4'd8) nack_d = sda_s2_q;
                        else               rx_d   = {rx_q[6:0], sda_s2_q};
                    end
                    if (phase_q == 2'd3) begin
                        if (bit_q != 4'd8) begin
                            bit_d = bit_q + 4'd1;
                        end else begin
                            bit_d   = 4'd0;
                            phase_d = 2'd0;
                            if (byte_q == B_RDATA) begin
                                rdata_d = rx_q;
                                state_d = S_STOP;
                            end else if (nack_q) begin
                                ack_err_d = 1'b1;
                                state_d   = S_STOP;
                            end else if (byte_q == B_WDATA) begin
                                state_d = S_STOP;
                            end else if (byte_q == B_REG && rw_q) begin
                                byte_d  = B_RSTART;
                                state_d = S_START;
                            end else if (byte_q == B_REG) begin
                                byte_d = B_WDATA;
                            end else if (byte_q == B_DEV_R) begin
                                byte_d = B_RDATA;
                            end else begin
                                byte_d = B_REG;
                            end
                        end
                    end
                end
            end
            S_STOP: begin
                if (phase_end) begin
                    if (phase_q == 2'd2) state_d = S_DONE;
                    else                 phase_d = phase_q + 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Line levels are registered from the next state so they change on phase boundaries only.
        case (byte_d)
            B_DEV_W: tx_byte = {dev_d, 1'b0};
            B_REG:   tx_byte = reg_d;
            B_WDATA: tx_byte = wdata_d;
            B_DEV_R: tx_byte = {dev_d, 1'b1};
            default: tx_byte = 8'hFF;
        endcase
        scl_d = 1'b1;
        sda_d = 1'b1;
        case (state_d)
            S_START: begin
                scl_d = (phase_d != 2'd0);
                sda_d = (phase_d != 2'd2);
            end
            S_BIT: begin
                scl_d = phase_d[1];
                sda_d = (bit_d == 4'd8) ? 1'b1 : tx_byte[3'd7 - bit_d[2:0]];
            end
            S_STOP: begin
                scl_d = (phase_d != 2'd0);
                sda_d = (phase_d == 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            byte_q    <= B_DEV_W;
            phase_q   <= 2'd0;
            cnt_q     <= 10'd0;
            bit_q     <= 4'd0;
            nack_q    <= 1'b0;
            rx_q      <= 8'h00;
            rw_q      <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            scl_s1_q  <= 1'b1;
            scl_s2_q  <= 1'b1;
            sda_s1_q  <= 1'b1;
            sda_s2_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            nack_q    <= nack_d;
            rx_q      <= rx_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            scl_s1_q  <= i_scl;
            scl_s2_q  <= scl_s1_q;
            sda_s1_q  <= i_sda;
            sda_s2_q  <= sda_s1_q;
        end
    end

    assign o_scl     = scl_q;
    assign o_sda     = sda_q;
    assign o_rdata   = rdata_q;
    assign o_ack_err = ack_err_q;
    assign o_busy    = (state_q == S_START) || (state_q == S_BIT) || (state_q == S_STOP);
    assign o_done    = (state_q == S_DONE);
endmodule

// File: tb/tb_lsc_i2cm_regrw.sv
// tb/tb_lsc_i2cm_regrw.sv - directed and randomized register transfers against a behavioural I2C slave
module tb_lsc_i2cm_regrw;
    localparam int         QDIV  = 8;
    localparam logic [6:0] SLV   = 7'h6E;
    localparam int         ST    = 32'h100;
    localparam int         SP    = 32'h101;
    localparam int         SR    = 32'h102;
    localparam int         MACK  = 32'h200;
    localparam int         MNACK = 32'h201;
    localparam int         LIMIT = 3000;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_start, i_rw;
    logic [6:0] i_dev_addr;
    logic [7:0] i_reg_addr, i_wdata;
    logic [7:0] o_rdata;
    logic       o_busy, o_done, o_ack_err, o_scl, o_sda;
    logic       sda_drv = 1'b1;
    logic       scl_hold_n = 1'b1;
    logic       scl_bus, sda_bus;

    assign scl_bus = o_scl & scl_hold_n;
    assign sda_bus = o_sda & sda_drv;

    always #5 clk = ~clk;

    lsc_i2cm_regrw #(.QDIV(QDIV)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_rw(i_rw),
        .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr), .i_wdata(i_wdata),
        .o_rdata(o_rdata), .o_busy(o_busy), .o_done(o_done), .o_ack_err(o_ack_err),
        .i_scl(scl_bus), .i_sda(sda_bus), .o_scl(o_scl), .o_sda(o_sda)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural slave at SLV plus bus sniffer; bytes, conditions and master ACK bits go to trace.
    logic [7:0] mem [256];
    int         trace[$];
    int         scl_rises;
    bit         stretch_arm = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    bit         in_frame, addressed, pend_tx, tx_mode, stretching;
    int         nbits, bidx, stretch_cnt;
    logic [7:0] rxb, txb, ptr;

    always @(negedge clk) begin
        logic cur_scl, cur_sda;
        cur_scl = scl_bus;
        cur_sda = sda_bus;
        if (reset) begin
            in_frame   = 1'b0;
            tx_mode    = 1'b0;
            pend_tx    = 1'b0;
            stretching = 1'b0;
            sda_drv    = 1'b1;
            scl_hold_n = 1'b1;
        end else begin
            if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
                trace.push_back(in_frame ? SR : ST);
                in_frame  = 1'b1;
                nbits     = 0;
                bidx      = 0;
                tx_mode   = 1'b0;
                pend_tx   = 1'b0;
                addressed = 1'b0;
                sda_drv   = 1'b1;
            end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
                trace.push_back(SP);
                in_frame = 1'b0;
                tx_mode  = 1'b0;
                sda_drv  = 1'b1;
            end else if (!prev_scl && cur_scl) begin
                scl_rises++;
                if (in_frame) begin
                    if (nbits < 8) begin
                        if (!tx_mode) rxb = {rxb[6:0], cur_sda};
                    end else if (tx_mode) begin
                        trace.push_back(cur_sda ? MNACK : MACK);
                    end
                    nbits++;
                end
            end else if (prev_scl && !cur_scl && in_frame) begin
                if (nbits == 8 && !tx_mode) begin
                    trace.push_back(int'(rxb));
                    if (bidx == 0) begin
                        addressed = (rxb[7:1] == SLV);
                        pend_tx   = addressed && rxb[0];
                    end else if (addressed) begin
                        if (bidx == 1) ptr = rxb;
                        else begin
                            mem[ptr] = rxb;
                            ptr++;
                        end
                    end
                    bidx++;
                    sda_drv = !addressed;
                end else if (nbits == 8) begin
                    trace.push_back(int'(txb));
                    sda_drv = 1'b1;
                end else if (nbits == 9) begin
                    nbits   = 0;
                    sda_drv = 1'b1;
                    tx_mode = 1'b0;
                    if (pend_tx) begin
                        pend_tx = 1'b0;
                        tx_mode = 1'b1;
                        txb     = mem[ptr];
                        ptr++;
                        sda_drv = txb[7];
                    end
                end else if (tx_mode && nbits >= 1) begin
                    sda_drv = txb[7 - nbits];
                end
                if (stretch_arm && bidx == 1 && nbits == 3 && !tx_mode) begin
                    scl_hold_n  = 1'b0;
                    stretching  = 1'b1;
                    stretch_arm = 1'b0;
                    stretch_cnt = 0;
                end
            end
            // Keep SCL low for 50 cycles beyond the master's own high-phase wait.
            if (stretching && o_scl) begin
                stretch_cnt++;
                if (stretch_cnt >= QDIV + 50) begin
                    scl_hold_n = 1'b1;
                    stretching = 1'b0;
                end
            end
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    // Reference model: register image of the slave and last successfully read byte.
    logic [7:0] exp_mem [256];
    logic [7:0] exp_rdata = 8'h00;

    task automatic do_txn(input string name, input logic rw, input logic [6:0] dev,
                          input logic [7:0] ra, input logic [7:0] wd,
                          input bit stretch, input bit poke);
        int   exp_q[$];
        int   b, exp_lat, exp_rises, lat;
        bit   acked, is_read, done_seen;
        acked   = (dev == SLV);
        is_read = acked && rw;
        exp_q   = {ST, int'({dev, 1'b0})};
        if (!acked) begin
            exp_q.push_back(SP);
            b = 9;
        end else if (!rw) begin
            exp_q.push_back(int'(ra));
            exp_q.push_back(int'(wd));
            exp_q.push_back(SP);
            b = 27;
            exp_mem[ra] = wd;
        end else begin
            exp_q.push_back(int'(ra));
            exp_q.push_back(SR);
            exp_q.push_back(int'({dev, 1'b1}));
            exp_q.push_back(int'(exp_mem[ra]));
            exp_q.push_back(MNACK);
            exp_q.push_back(SP);
            b = 36;
            exp_rdata = exp_mem[ra];
        end
        exp_lat   = 1 + 4 * QDIV * b + 6 * QDIV + (is_read ? 3 * QDIV : 0) + 1;
        exp_rises = b + 2 + (is_read ? 1 : 0);

        @(negedge clk);
        trace.delete();
        scl_rises   = 0;
        stretch_arm = stretch;
        i_rw        = rw;
        i_dev_addr  = dev;
        i_reg_addr  = ra;
        i_wdata     = wd;
        i_start     = 1'b1;
        lat         = 1;
        done_seen   = 1'b0;
        for (int k = 0; k < LIMIT && !done_seen; k++) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
            if (poke && k == 40) begin
                i_start    = 1'b1;
                i_rw       = ~rw;
                i_dev_addr = dev ^ 7'h55;
                i_reg_addr = ~ra;
                i_wdata    = ~wd;
            end
            lat++;
            if (k == 0) check({name, "_busy_after_accept"}, o_busy, 1'b1);
            if (o_done) done_seen = 1'b1;
        end
        i_start = 1'b0;
        check({name, "_done_seen"}, done_seen, 1'b1);
        check({name, "_busy_at_done"}, o_busy, 1'b0);
        if (stretch) begin
            check({name, "_lat_stretch_window"},
                  (lat >= exp_lat + 50) && (lat <= exp_lat + 54), 1'b1);
        end else begin
            check({name, "_latency"}, lat, exp_lat);
        end
        check({name, "_ack_err"}, o_ack_err, !acked);
        check({name, "_rdata"}, o_rdata, exp_rdata);
        @(posedge clk);
        #1;
        check({name, "_done_one_cycle"}, o_done, 1'b0);
        repeat (2 * QDIV) @(posedge clk);
        #1;
        check({name, "_scl_pulses"}, scl_rises, exp_rises);
        check({name, "_trace_len"}, trace.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
            check($sformatf("%s_trace%0d", name, i), trace[i], exp_q[i]);
        if (acked && !rw) check({name, "_slave_mem"}, mem[ra], wd);
    endtask

    initial begin
        logic [6:0] rdev;
        logic       rrw;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 37 + 11);
            exp_mem[i] = 8'(i * 37 + 11);
        end
        mem[8'h10]     = 8'h3C;
        exp_mem[8'h10] = 8'h3C;
        reset      = 1'b1;
        i_start    = 1'b0;
        i_rw       = 1'b0;
        i_dev_addr = 7'h00;
        i_reg_addr = 8'h00;
        i_wdata    = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("rst_scl", o_scl, 1'b1);
        check("rst_sda", o_sda, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_ack_err", o_ack_err, 1'b0);
        check("rst_rdata", o_rdata, 8'h00);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        do_txn("wr_a5", 1'b0, SLV, 8'h00, 8'hA5, 1'b0, 1'b0);
        do_txn("rd_3c", 1'b1, SLV, 8'h10, 8'h00, 1'b0, 1'b0);
        do_txn("wr_absent", 1'b0, 7'h12, 8'h04, 8'h99, 1'b0, 1'b0);
        do_txn("wr_after_nack", 1'b0, SLV, 8'h21, 8'h5A, 1'b0, 1'b0);
        do_txn("wr_stretch", 1'b0, SLV, 8'h31, 8'hC3, 1'b1, 1'b0);
        do_txn("wr_poke", 1'b0, SLV, 8'h42, 8'h81, 1'b0, 1'b1);
        do_txn("rd_back", 1'b1, SLV, 8'h42, 8'h00, 1'b0, 1'b0);

        // Reset in the middle of the register byte of a write.
        @(negedge clk);
        i_rw       = 1'b0;
        i_dev_addr = SLV;
        i_reg_addr = 8'h22;
        i_wdata    = 8'h77;
        i_start    = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (3 * QDIV + 36 * QDIV + 14 * QDIV) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_scl", o_scl, 1'b1);
        check("midrst_sda", o_sda, 1'b1);
        check("midrst_busy", o_busy, 1'b0);
        reset     = 1'b0;
        exp_rdata = 8'h00;
        repeat (4) @(posedge clk);
        do_txn("wr_after_rst", 1'b0, SLV, 8'h23, 8'h6D, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            rrw  = 1'($urandom_range(0, 1));
            rdev = SLV;
            if ($urandom_range(0, 3) == 0) begin
                rdev = 7'($urandom);
                if (rdev == SLV) rdev = rdev ^ 7'h01;
            end
            do_txn($sformatf("rnd%0d", n), rrw, rdev, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
